arbitro_mux4: RTL and testbench

//  Round-robin arbiter that shares the 8-bit 4:1 datapath mux among four requesters.

---
 rtl/arbitro_mux4_pkg.sv | 15 +
 rtl/arbitro_mux4_prioridade_rr.sv | 29 ++
 rtl/arbitro_mux4.sv | 119 +++++++++++
 tb/tb_arbitro_mux4.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arbitro_mux4_pkg.sv
// Shared types for the round-robin arbiter of the 4:1 data mux.
// FSM encoding and port-index constants.
package arbitro_mux4_pkg;

   typedef enum logic {
      OCIOSO    = 1'b0,
      CONCEDIDO = 1'b1
   } estado_t;

   localparam logic [1:0] PORTA1 = 2'd0;
   localparam logic [1:0] PORTA2 = 2'd1;
   localparam logic [1:0] PORTA3 = 2'd2;
   localparam logic [1:0] PORTA4 = 2'd3;

endpackage

// File: rtl/arbitro_mux4_prioridade_rr.sv
// Combinational 4-bit rotating priority picker.
// Search starts at ponteiro and wraps around.
module prioridade_rr (
   input  logic [3:0] requisicao,
   input  logic [1:0] ponteiro,
   output logic [3:0] vencedor,
   output logic [1:0] indice,
   output logic       algum
);

   logic [1:0] cand;

   always_comb begin
      cand     = ponteiro;
      indice   = 2'd0;
      algum    = 1'b0;
      vencedor = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         cand = ponteiro + 2'(i);
         if (!algum && requisicao[cand]) begin
            algum  = 1'b1;
            indice = cand;
         end
      end
      if (algum)
         vencedor = 4'b0001 << indice;
   end

endmodule

// File: rtl/arbitro_mux4.sv
// Round-robin arbiter with burst limit sharing an 8-bit 4:1 mux.
// Grant and select are registered together; saida is combinational.
module arbitro_mux4
   import arbitro_mux4_pkg::*;
#(
   parameter int LARGURA    = 8,
   parameter int MAX_RAJADA = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [3:0]         requisicao,
   input  logic [LARGURA-1:0] porta1,
   input  logic [LARGURA-1:0] porta2,
   input  logic [LARGURA-1:0] porta3,
   input  logic [LARGURA-1:0] porta4,
   output logic [3:0]         concessao,
   output logic [1:0]         selecao,
   output logic               valido,
   output logic [LARGURA-1:0] saida,
   output logic               preempcao
);

   localparam int CW = (MAX_RAJADA > 1) ? $clog2(MAX_RAJADA) : 1;
   localparam logic [CW-1:0] LIMITE = CW'(MAX_RAJADA - 1);

   estado_t       estado, estado_n;
   logic [1:0]    ponteiro, ponteiro_n;
   logic [CW-1:0] contador, contador_n;
   logic [3:0]    concessao_n;
   logic [1:0]    selecao_n;
   logic          preempcao_n;

   logic [3:0]    vencedor;
   logic [1:0]    indice;
   logic          algum;

   // Owner bit is masked so a forced switch always picks someone else.
   prioridade_rr u_rr (
      .requisicao (requisicao & ~concessao),
      .ponteiro   (ponteiro),
      .vencedor   (vencedor),
      .indice     (indice),
      .algum      (algum)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         estado    <= OCIOSO;
         ponteiro  <= 2'd0;
         contador  <= '0;
         concessao <= 4'b0000;
         selecao   <= 2'd0;
         preempcao <= 1'b0;
      end else begin
         estado    <= estado_n;
         ponteiro  <= ponteiro_n;
         contador  <= contador_n;
         concessao <= concessao_n;
         selecao   <= selecao_n;
         preempcao <= preempcao_n;
      end
   end

   always_comb begin
      estado_n    = estado;
      ponteiro_n  = ponteiro;
      contador_n  = contador;
      concessao_n = concessao;
      selecao_n   = selecao;
      preempcao_n = 1'b0;
      unique case (estado)
         OCIOSO: begin
            if (algum) begin
               estado_n    = CONCEDIDO;
               concessao_n = vencedor;
               selecao_n   = indice;
               ponteiro_n  = indice + 2'd1;
               contador_n  = '0;
            end
         end
         CONCEDIDO: begin
            if (!requisicao[selecao]) begin
               if (algum) begin
                  concessao_n = vencedor;
                  selecao_n   = indice;
                  ponteiro_n  = indice + 2'd1;
                  contador_n  = '0;
               end else begin
                  estado_n    = OCIOSO;
                  concessao_n = 4'b0000;
               end
            end else if (contador == LIMITE) begin
               if (algum) begin
                  concessao_n = vencedor;
                  selecao_n   = indice;
                  ponteiro_n  = indice + 2'd1;
                  contador_n  = '0;
                  preempcao_n = 1'b1;
               end
            end else begin
               contador_n = contador + 1'b1;
            end
         end
         default: estado_n = OCIOSO;
      endcase
   end

   always_comb begin
      valido = |concessao;
      unique case (selecao)
         PORTA1:  saida = porta1;
         PORTA2:  saida = porta2;
         PORTA3:  saida = porta3;
         PORTA4:  saida = porta4;
         default: saida = porta1;
      endcase
   end

endmodule

// File: tb/tb_arbitro_mux4.sv
// Directed bench for arbitro_mux4: reset, latency, rotation,
// burst limit, handover, reset mid-grant, random invariants.
module tb_arbitro_mux4;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] requisicao;
   logic [7:0] porta1, porta2, porta3, porta4;
   logic [3:0] concessao;
   logic [1:0] selecao;
   logic       valido;
   logic [7:0] saida;
   logic       preempcao;

   int checks = 0;
   int errors = 0;
   int espera [4];
   logic [7:0] esperado;
   logic [3:0] r;

   arbitro_mux4 #(.LARGURA(8), .MAX_RAJADA(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .requisicao (requisicao),
      .porta1     (porta1),
      .porta2     (porta2),
      .porta3     (porta3),
      .porta4     (porta4),
      .concessao  (concessao),
      .selecao    (selecao),
      .valido     (valido),
      .saida      (saida),
      .preempcao  (preempcao)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      requisicao = 4'b0000;
      porta1 = 8'hA1;
      porta2 = 8'hB2;
      porta3 = 8'hC3;
      porta4 = 8'hD4;
      tick();
      tick();
      chk("rst_conc", {4'b0, concessao}, 8'h00);
      chk("rst_sel", {6'b0, selecao}, 8'h00);
      chk("rst_val", {7'b0, valido}, 8'h00);
      chk("rst_pre", {7'b0, preempcao}, 8'h00);

      // single request, one-cycle latency
      reset = 1'b0;
      requisicao = 4'b0010;
      tick();
      chk("t1_conc", {4'b0, concessao}, 8'h02);
      chk("t1_sel", {6'b0, selecao}, 8'h01);
      chk("t1_saida", saida, 8'hB2);
      chk("t1_val", {7'b0, valido}, 8'h01);
      requisicao = 4'b0000;
      tick();
      chk("idle_conc", {4'b0, concessao}, 8'h00);
      chk("idle_val", {7'b0, valido}, 8'h00);
      chk("idle_sel_hold", {6'b0, selecao}, 8'h01);
      chk("idle_saida", saida, 8'hB2);

      // all request: rotate every 4 cycles with preemption pulses
      reset = 1'b1;
      tick();
      reset = 1'b0;
      requisicao = 4'b1111;
      tick();
      for (int i = 0; i < 20; i++) begin
         esperado = 8'h01 << ((i / 4) % 4);
         chk("t2_conc", {4'b0, concessao}, esperado);
         chk("t2_pre", {7'b0, preempcao},
             {7'b0, (i % 4 == 0) && (i != 0)});
         tick();
      end

      // lone owner keeps the grant past the burst limit
      reset = 1'b1;
      requisicao = 4'b0000;
      tick();
      reset = 1'b0;
      requisicao = 4'b0100;
      tick();
      for (int i = 0; i < 20; i++) begin
         chk("t3_conc", {4'b0, concessao}, 8'h04);
         chk("t3_pre", {7'b0, preempcao}, 8'h00);
         tick();
      end
      chk("t3_saida", saida, 8'hC3);

      // release hands over directly, no idle bubble
      reset = 1'b1;
      requisicao = 4'b0000;
      tick();
      reset = 1'b0;
      requisicao = 4'b0001;
      tick();
      chk("t4_own", {4'b0, concessao}, 8'h01);
      requisicao = 4'b1001;
      tick();
      chk("t4_keep", {4'b0, concessao}, 8'h01);
      requisicao = 4'b1000;
      tick();
      chk("t4_conc", {4'b0, concessao}, 8'h08);
      chk("t4_val", {7'b0, valido}, 8'h01);
      chk("t4_sel", {6'b0, selecao}, 8'h03);
      chk("t4_saida", saida, 8'hD4);
      chk("t4_pre", {7'b0, preempcao}, 8'h00);

      // reset in the middle of a grant
      requisicao = 4'b0100;
      tick();
      tick();
      chk("t5_own", {4'b0, concessao}, 8'h04);
      reset = 1'b1;
      tick();
      chk("t5_conc", {4'b0, concessao}, 8'h00);
      chk("t5_val", {7'b0, valido}, 8'h00);
      chk("t5_sel", {6'b0, selecao}, 8'h00);
      reset = 1'b0;
      requisicao = 4'b1111;
      tick();
      chk("t5_ptr0", {4'b0, concessao}, 8'h01);

      // random traffic: requesters hold until served
      reset = 1'b1;
      requisicao = 4'b0000;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) espera[k] = 0;
      for (int n = 0; n < 3000; n++) begin
         chk("t6_onehot", {7'b0, $onehot0(concessao)}, 8'h01);
         chk("t6_selval", {7'b0, concessao[selecao]}, {7'b0, valido});
         chk("t6_valor", {7'b0, valido}, {7'b0, concessao != 4'b0});
         unique case (selecao)
            2'd0: esperado = porta1;
            2'd1: esperado = porta2;
            2'd2: esperado = porta3;
            default: esperado = porta4;
         endcase
         chk("t6_saida", saida, esperado);
         for (int k = 0; k < 4; k++) begin
            if (requisicao[k] && !concessao[k]) espera[k]++;
            else espera[k] = 0;
            chk("t6_starve", {7'b0, espera[k] > 12}, 8'h00);
         end
         r = requisicao;
         for (int k = 0; k < 4; k++) begin
            if (r[k] && concessao[k])
               r[k] = ($urandom_range(3) != 0);
            else if (!r[k])
               r[k] = $urandom_range(1) == 1;
         end
         requisicao = r;
         porta1 = 8'($urandom);
         porta2 = 8'($urandom);
         porta3 = 8'($urandom);
         porta4 = 8'($urandom);
         #1;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
